// File: rtl/bp_cacc_fwd_initiator.sv
// Host-side CSR initiator: turns one simple command into a single-beat uncached BedRock mem_fwd
// and returns the aligned mem_rev data. Optional response timeout: define BP_CACC_FWD_TIMEOUT_EN.
module bp_cacc_fwd_initiator #(
    parameter int paddr_width_p    = 40,
    parameter int did_width_p      = 1,
    parameter int lce_id_width_p   = 4,
    parameter int data_width_p     = 64,
    parameter int timeout_cycles_p = 1024,
    localparam int mem_fwd_header_width_lp = 11 + paddr_width_p + lce_id_width_p + did_width_p,
    localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [lce_id_width_p-1:0]          lce_id_i,
    input  logic [did_width_p-1:0]             did_i,
    input  logic                               cmd_v_i,
    output logic                               cmd_ready_and_o,
    input  logic                               cmd_we_i,
    input  logic [paddr_width_p-1:0]           cmd_addr_i,
    input  logic [1:0]                         cmd_size_i,
    input  logic [data_width_p-1:0]            cmd_data_i,
    output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
    output logic [data_width_p-1:0]            mem_fwd_data_o,
    output logic                               mem_fwd_v_o,
    input  logic                               mem_fwd_ready_and_i,
    input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
    input  logic [data_width_p-1:0]            mem_rev_data_i,
    input  logic                               mem_rev_v_i,
    output logic                               mem_rev_ready_and_o,
    output logic                               resp_v_o,
    input  logic                               resp_ready_and_i,
    output logic [data_width_p-1:0]            resp_data_o,
    output logic                               resp_err_o,
    output logic                               unexpected_o
);

    localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;
    localparam logic [3:0] e_bedrock_store     = 4'd0;

    typedef struct packed {
        logic [did_width_p-1:0]    did;
        logic [lce_id_width_p-1:0] lce_id;
        logic [2:0]                size;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                subop;
        logic [3:0]                msg_type;
    } bedrock_mem_header_s;

    typedef enum logic [1:0] {e_ready, e_send, e_wait, e_resp} state_e;

    state_e state_r, state_n;

    logic                      we_r;
    logic [paddr_width_p-1:0]  addr_r;
    logic [1:0]                size_r;
    logic [data_width_p-1:0]   wdata_r;
    logic [data_width_p-1:0]   resp_data_r;
    logic                      resp_err_r;
    logic                      unexpected_r;

    bedrock_mem_header_s       fwd_header, rev_header;
    logic [3:0]                sent_msg_type;
    logic [data_width_p-1:0]   rev_shifted, size_mask, fwd_data;
    logic                      rev_mismatch;
    logic                      timeout_hit;
    logic                      unused_rev_bits;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready: if (cmd_v_i)                    state_n = e_send;
            e_send:  if (mem_fwd_ready_and_i)        state_n = e_wait;
            e_wait:  if (mem_rev_v_i || timeout_hit) state_n = e_resp;
            e_resp:  if (resp_ready_and_i)           state_n = e_ready;
            default:                                 state_n = e_ready;
        endcase
    end

    always_comb begin
        cmd_ready_and_o = 1'b0;
        mem_fwd_v_o     = 1'b0;
        resp_v_o        = 1'b0;
        unique case (state_r)
            e_ready: cmd_ready_and_o = ~reset_i;
            e_send:  mem_fwd_v_o     = 1'b1;
            e_resp:  resp_v_o        = 1'b1;
            default: ;
        endcase
    end

    // Outside e_wait the rev channel stays ready so strays are drained instead of blocking the responder
    assign mem_rev_ready_and_o = 1'b1;

    assign sent_msg_type = we_r ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;

    always_comb begin
        fwd_header          = '0;
        fwd_header.msg_type = sent_msg_type;
        fwd_header.subop    = e_bedrock_store;
        fwd_header.addr     = addr_r;
        fwd_header.size     = {1'b0, size_r};
        fwd_header.lce_id   = lce_id_i;
        fwd_header.did      = did_i;
    end

    assign mem_fwd_header_o = fwd_header;

    always_comb begin
        fwd_data = '0;
        unique case (size_r)
            2'd0:    fwd_data = {(data_width_p/8){wdata_r[7:0]}};
            2'd1:    fwd_data = {(data_width_p/16){wdata_r[15:0]}};
            2'd2:    fwd_data = {(data_width_p/32){wdata_r[31:0]}};
            default: fwd_data = {(data_width_p/64){wdata_r[63:0]}};
        endcase
    end

    assign mem_fwd_data_o = we_r ? fwd_data : '0;

    assign rev_header      = mem_rev_header_i;
    assign rev_mismatch    = (rev_header.msg_type != sent_msg_type) | (rev_header.addr != addr_r);
    assign unused_rev_bits = ^{rev_header.subop, rev_header.size, rev_header.lce_id, rev_header.did};

    assign rev_shifted = mem_rev_data_i >> {addr_r[2:0], 3'b000};

    always_comb begin
        size_mask = '1;
        unique case (size_r)
            2'd0:    size_mask = data_width_p'(8'hFF);
            2'd1:    size_mask = data_width_p'(16'hFFFF);
            2'd2:    size_mask = data_width_p'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
    end

`ifdef BP_CACC_FWD_TIMEOUT_EN
    localparam int cnt_width_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

    logic [cnt_width_lp-1:0] wait_cnt_r;

    // Counter sits at zero outside e_wait, so it is already cleared on entry
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_cnt_r <= '0;
        end else if (state_r != e_wait) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + cnt_width_lp'(1);
        end
    end

    assign timeout_hit = (state_r == e_wait) && !mem_rev_v_i
                         && (wait_cnt_r == cnt_width_lp'(timeout_cycles_p - 1));
`else
    localparam int unused_timeout_lp = timeout_cycles_p;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_r        <= 1'b0;
            addr_r      <= '0;
            size_r      <= '0;
            wdata_r     <= '0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else begin
            if (state_r == e_ready && cmd_v_i) begin
                we_r    <= cmd_we_i;
                addr_r  <= cmd_addr_i;
                size_r  <= cmd_size_i;
                wdata_r <= cmd_data_i;
            end
            if (state_r == e_wait) begin
                if (mem_rev_v_i) begin
                    resp_data_r <= we_r ? '0 : (rev_shifted & size_mask);
                    resp_err_r  <= rev_mismatch;
                end else if (timeout_hit) begin
                    resp_data_r <= '0;
                    resp_err_r  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            unexpected_r <= 1'b0;
        end else if (mem_rev_v_i && state_r != e_wait) begin
            unexpected_r <= 1'b1;
        end
    end

    assign resp_data_o  = resp_data_r;
    assign resp_err_o   = resp_err_r;
    assign unexpected_o = unexpected_r;

endmodule
